// File: rtl/muladd_pkg.sv
// muladd_pkg: shared sizes, FSM state type and helpers for the PE multiply-add scheduler
package muladd_pkg;
    localparam int LANES  = 8;
    localparam int OP_W   = 16;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = 4;
    localparam int LANE_W = 2 * OP_W;
    localparam int LCNT_W = $clog2(LANES);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} sched_state_t;
    typedef logic [ACC_W-1:0] acc_t;

    // a programmed length of zero still produces one result per vector
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction
endpackage

// File: rtl/muladd_pe_sched_if.sv
// muladd_pe_sched_if: operand-vector and result valid/ready channels of the PE scheduler
interface muladd_pe_sched_if;
    import muladd_pkg::*;
    logic                    vec_valid_i;
    logic [LANES*LANE_W-1:0] vec_data_i;
    logic                    vec_ready_o;
    logic                    result_valid_o;
    acc_t                    result_payload_o;
    logic                    result_ready_i;

    modport slave (
        input  vec_valid_i, vec_data_i, result_ready_i,
        output vec_ready_o, result_valid_o, result_payload_o
    );
    modport master (
        output vec_valid_i, vec_data_i, result_ready_i,
        input  vec_ready_o, result_valid_o, result_payload_o
    );
endinterface

// File: rtl/muladd_mac_lane.sv
// muladd_mac_lane: unsigned a*b added to a running sum, wrapping modulo 2^ACC_W
module muladd_mac_lane
    import muladd_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  acc_t            acc_in,
    output acc_t            acc_out
);
    logic [2*OP_W-1:0] prod;

    assign prod    = a * b;
    assign acc_out = acc_in + acc_t'(prod);
endmodule

// File: rtl/muladd_pe_sched.sv
// muladd_pe_sched: streams the lanes of each operand vector through one shared MAC and
// emits the sum accumulated over a configurable number of vectors
module muladd_pe_sched
    import muladd_pkg::*;
(
    input  logic             clk_pe,
    input  logic             rst_n,
    muladd_pe_sched_if.slave bus,
    input  logic [CNT_W-1:0] cfg_acc_len_i,
    output logic             busy_o
);
    sched_state_t            state_q, state_d;
    logic [LANES*LANE_W-1:0] vec_q;
    logic [LCNT_W-1:0]       lane_cnt;
    logic [CNT_W-1:0]        vec_cnt, len_q;
    acc_t                    acc, mac_out, payload_q;
    logic [OP_W-1:0]         op_a, op_b;
    logic                    accept, last_lane, last_vec;

    assign op_a      = vec_q[lane_cnt*LANE_W +: OP_W];
    assign op_b      = vec_q[lane_cnt*LANE_W+OP_W +: OP_W];
    assign accept    = (state_q == S_IDLE) & bus.vec_valid_i;
    assign last_lane = lane_cnt == LCNT_W'(LANES-1);
    assign last_vec  = vec_cnt == len_q - 1'b1;

    assign bus.vec_ready_o      = (state_q == S_IDLE) & rst_n;
    assign bus.result_valid_o   = state_q == S_OUT;
    assign bus.result_payload_o = payload_q;
    assign busy_o               = (state_q != S_IDLE) | (vec_cnt != '0);

    muladd_mac_lane u_mac (
        .a       (op_a),
        .b       (op_b),
        .acc_in  (acc),
        .acc_out (mac_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_MAC : S_IDLE;
            S_MAC:   if (last_lane) state_d = last_vec ? S_OUT : S_IDLE;
            S_OUT:   if (bus.result_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_pe) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            vec_q     <= '0;
            lane_cnt  <= '0;
            vec_cnt   <= '0;
            len_q     <= '0;
            acc       <= '0;
            payload_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                vec_q    <= bus.vec_data_i;
                lane_cnt <= '0;
                if (vec_cnt == '0) len_q <= eff_len(cfg_acc_len_i);
            end
            if (state_q == S_MAC) begin
                acc      <= mac_out;
                lane_cnt <= lane_cnt + 1'b1;
                if (last_lane && last_vec) begin
                    payload_q <= mac_out;
                    vec_cnt   <= '0;
                end else if (last_lane) begin
                    vec_cnt <= vec_cnt + 1'b1;
                end
            end
            // acc is kept between vectors of one result and cleared once the result is taken
            if (state_q == S_OUT && bus.result_ready_i) acc <= '0;
        end
    end
endmodule

// File: tb/tb_muladd_pe_sched.sv
// tb_muladd_pe_sched: directed checks of the PE multiply-add scheduler with hand-computed sums
module tb_muladd_pe_sched;
    import muladd_pkg::*;

    logic             clk_pe = 1'b0;
    logic             rst_n  = 1'b0;
    logic [CNT_W-1:0] cfg    = 4'd1;
    logic             busy;
    int               checks   = 0;
    int               failures = 0;

    always #5 clk_pe = ~clk_pe;

    muladd_pe_sched_if bus ();

    muladd_pe_sched dut (
        .clk_pe        (clk_pe),
        .rst_n         (rst_n),
        .bus           (bus),
        .cfg_acc_len_i (cfg),
        .busy_o        (busy)
    );

    task automatic tick;
        @(posedge clk_pe);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*LANE_W-1:0] vec_const(input logic [15:0] a, input logic [15:0] b);
        logic [LANES*LANE_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[32*i +: 32] = {b, a};
        return v;
    endfunction

    function automatic logic [LANES*LANE_W-1:0] vec_ramp(input logic [15:0] b);
        logic [LANES*LANE_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[32*i +: 32] = {b, 16'(i)};
        return v;
    endfunction

    task automatic send_vec(input string tag, input logic [LANES*LANE_W-1:0] d);
        int n = 0;
        bus.vec_valid_i = 1'b1;
        bus.vec_data_i  = d;
        while (!bus.vec_ready_o && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_ready"}, 32'(bus.vec_ready_o), 32'd1);
        tick;
        bus.vec_valid_i = 1'b0;
        bus.vec_data_i  = '0;
    endtask

    task automatic collect(input string tag, input logic [31:0] exp);
        int n = 0;
        while (!bus.result_valid_o && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.result_valid_o), 32'd1);
        chk({tag, "_payload"}, bus.result_payload_o, exp);
        bus.result_ready_i = 1'b1;
        tick;
        bus.result_ready_i = 1'b0;
        chk({tag, "_done"}, 32'(bus.result_valid_o), 32'd0);
    endtask

    initial begin
        bus.vec_valid_i    = 1'b0;
        bus.vec_data_i     = '0;
        bus.result_ready_i = 1'b0;
        tick;
        tick;
        chk("rst_vec_ready", 32'(bus.vec_ready_o), 32'd0);
        chk("rst_valid", 32'(bus.result_valid_o), 32'd0);
        chk("rst_payload", bus.result_payload_o, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick;
        chk("idle_vec_ready", 32'(bus.vec_ready_o), 32'd1);

        // 1: all ones, exact latency
        cfg = 4'd1;
        send_vec("t1", vec_const(16'd1, 16'd1));
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_not_ready", 32'(bus.vec_ready_o), 32'd0);
        for (int i = 0; i < LANES-1; i++) begin
            tick;
            chk("t1_early_valid", 32'(bus.result_valid_o), 32'd0);
        end
        tick;
        chk("t1_latency", 32'(bus.result_valid_o), 32'd1);
        collect("t1", 32'h0000_0008);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 2: two ramp vectors summed into one result
        cfg = 4'd2;
        send_vec("t2a", vec_ramp(16'd2));
        for (int i = 0; i < LANES; i++) begin
            tick;
            chk("t2_no_mid_valid", 32'(bus.result_valid_o), 32'd0);
        end
        chk("t2_mid_busy", 32'(busy), 32'd1);
        send_vec("t2b", vec_ramp(16'd2));
        collect("t2", 32'h0000_0070);

        // 3: wraparound
        cfg = 4'd1;
        send_vec("t3", vec_const(16'hFFFF, 16'hFFFF));
        collect("t3", 32'hFFF0_0008);

        // 4: consumer stalls while a new vector waits
        send_vec("t4", vec_const(16'd1, 16'd1));
        repeat (LANES) tick;
        bus.vec_valid_i = 1'b1;
        bus.vec_data_i  = vec_const(16'd1, 16'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(bus.result_valid_o), 32'd1);
            chk("t4_hold_payload", bus.result_payload_o, 32'h0000_0008);
            chk("t4_hold_not_ready", 32'(bus.vec_ready_o), 32'd0);
            tick;
        end
        bus.result_ready_i = 1'b1;
        tick;
        bus.result_ready_i = 1'b0;
        chk("t4_hs_valid", 32'(bus.result_valid_o), 32'd0);
        chk("t4_hs_ready", 32'(bus.vec_ready_o), 32'd1);
        chk("t4_hs_busy", 32'(busy), 32'd0);
        tick;
        bus.vec_valid_i = 1'b0;
        chk("t4_accepted", 32'(busy), 32'd1);
        chk("t4_accepted_ready", 32'(bus.vec_ready_o), 32'd0);
        collect("t4b", 32'h0000_0008);

        // 5: reset in the middle of a vector
        send_vec("t5", vec_const(16'hFFFF, 16'hFFFF));
        repeat (4) tick;
        rst_n = 1'b0;
        tick;
        chk("t5_rst_valid", 32'(bus.result_valid_o), 32'd0);
        chk("t5_rst_payload", bus.result_payload_o, 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", 32'(bus.vec_ready_o), 32'd0);
        rst_n = 1'b1;
        tick;
        send_vec("t5b", vec_const(16'd1, 16'd1));
        collect("t5b", 32'h0000_0008);

        // 6a: zero length acts as one
        cfg = 4'd0;
        send_vec("t6a", vec_const(16'd1, 16'd1));
        collect("t6a", 32'h0000_0008);

        // 6b: length sampled only at the first vector: 8 + 56 + 120
        cfg = 4'd3;
        send_vec("t6b1", vec_const(16'd1, 16'd1));
        repeat (LANES) tick;
        cfg = 4'd1;
        send_vec("t6b2", vec_ramp(16'd2));
        repeat (LANES) tick;
        chk("t6b_no_early", 32'(bus.result_valid_o), 32'd0);
        send_vec("t6b3", vec_const(16'd3, 16'd5));
        collect("t6b", 32'h0000_00B8);

        // reset while idle must drop ready
        rst_n = 1'b0;
        #1;
        chk("idle_rst_ready", 32'(bus.vec_ready_o), 32'd0);
        tick;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
